// File: rtl/cam_match_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_match_checker_pkg                                           |
// | Purpose  : Shared constants, counter type and saturating-increment helper  |
// |            for the CAM match checker and its priority encoder.             |
// | Contents : ERR_* bit positions of the error-kind vector, CNT_W counter     |
// |            width, cnt_t counter type, sat_inc() helper.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cam_match_checker_pkg;

    // Bit positions inside the 4-bit error-kind vector
    localparam int ERR_MATCH  = 0;
    localparam int ERR_ADDR   = 1;
    localparam int ERR_MANY   = 2;
    localparam int ERR_SINGLE = 3;
    localparam int ERR_KIND_W = 4;

    // Statistics counter width
    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping to zero
    function automatic cnt_t sat_inc(input cnt_t cnt, input logic inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + cnt_t'(1);
        end
        return cnt;
    endfunction

endpackage : cam_match_checker_pkg
`default_nettype wire

// File: rtl/cam_match_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_match_checker_if                                            |
// | Purpose  : Bundles the snooped CAM write port, the search key and the CAM  |
// |            match outputs.                                                  |
// | Ports    : (signals) write_addr/data/delete/enable/busy, compare_data,     |
// |            match_many, match_single, match_addr, match                     |
// |            modport master : driven by the CAM / stimulus side              |
// |            modport slave  : observed by the checker                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cam_match_checker_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) ();

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_delete;
    logic                  write_enable;
    logic                  write_busy;
    logic [DATA_WIDTH-1:0] compare_data;
    logic [DEPTH-1:0]      match_many;
    logic [DEPTH-1:0]      match_single;
    logic [ADDR_WIDTH-1:0] match_addr;
    logic                  match;

    modport master (
        output write_addr, write_data, write_delete, write_enable, write_busy,
        output compare_data,
        output match_many, match_single, match_addr, match
    );

    modport slave (
        input write_addr, write_data, write_delete, write_enable, write_busy,
        input compare_data,
        input match_many, match_single, match_addr, match
    );

endinterface : cam_match_checker_if
`default_nettype wire

// File: rtl/cam_match_checker_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_prio_enc                                                    |
// | Purpose  : Lowest-index priority encoder for a CAM match vector.           |
// | Ports    : vec_i    in  2**AW  per-entry match vector                      |
// |            onehot_o out 2**AW  lowest set bit of vec_i, zero if none       |
// |            addr_o   out AW     index of that bit, zero if none             |
// |            any_o    out 1      OR of vec_i                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cam_prio_enc #(
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic [2**ADDR_WIDTH-1:0] vec_i,
    output logic      [2**ADDR_WIDTH-1:0] onehot_o,
    output logic      [ADDR_WIDTH-1:0]    addr_o,
    output logic                          any_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // x & -x isolates the lowest set bit
    assign onehot_o = vec_i & ((~vec_i) + DEPTH'(1));
    assign any_o    = |vec_i;

    // Scan from the top down so the lowest set index is written last and wins
    always_comb begin
        addr_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                addr_o = ADDR_WIDTH'(i);
            end
        end
    end

endmodule : cam_prio_enc
`default_nettype wire

// File: rtl/cam_match_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_match_checker                                               |
// | Purpose  : Snoops CAM writes into a shadow table, predicts the match       |
// |            vector / one-hot / address for each search key, and checks the  |
// |            CAM outputs MATCH_LATENCY cycles later. Keeps compare, hit and  |
// |            error statistics and latches the first mismatch.                |
// | Ports    : clk, rst_n (sync, active low)                                   |
// |            cam             slave view of the CAM write/search/match bus    |
// |            check_en_i      allow sampling of new compares                  |
// |            clear_stats_i   clear counters and first-error capture          |
// |            cmp/hit/err_count_o  saturating statistics                      |
// |            err_flag_o, err_kind_o, err_data_o, err_exp_addr_o,             |
// |            err_got_addr_o  first-error capture                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cam_match_checker
    import cam_match_checker_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int MATCH_LATENCY = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    cam_match_checker_if.slave          cam,
    input  wire logic                   check_en_i,
    input  wire logic                   clear_stats_i,
    output cnt_t                        cmp_count_o,
    output cnt_t                        hit_count_o,
    output cnt_t                        err_count_o,
    output logic                        err_flag_o,
    output logic [ERR_KIND_W-1:0]       err_kind_o,
    output logic [DATA_WIDTH-1:0]       err_data_o,
    output logic [ADDR_WIDTH-1:0]       err_exp_addr_o,
    output logic [ADDR_WIDTH-1:0]       err_got_addr_o
);

    localparam int DEPTH    = 2**ADDR_WIDTH;
    localparam int LAST     = MATCH_LATENCY - 1;
    localparam int SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    // ------------------------------------------------------------------
    // Write snoop and shadow table
    // ------------------------------------------------------------------
    logic acc;
    assign acc = cam.write_enable & ~cam.write_busy;

    logic [DATA_WIDTH-1:0] shadow_data_q [DEPTH];
    logic [DEPTH-1:0]      shadow_valid_q, shadow_valid_d;

    always_comb begin
        shadow_valid_d = shadow_valid_q;
        if (acc) begin
            shadow_valid_d[cam.write_addr] = ~cam.write_delete;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_valid_q <= '0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
        end
    end

    // Data is only meaningful where the valid bit is set, so it needs no reset;
    // a delete keeps the old data bits.
    always_ff @(posedge clk) begin
        if (acc && !cam.write_delete) begin
            shadow_data_q[cam.write_addr] <= cam.write_data;
        end
    end

    // ------------------------------------------------------------------
    // Settle counter: keeps checks off while the CAM may still be updating
    // ------------------------------------------------------------------
    logic [SETTLE_W-1:0] settle_q, settle_d;

    always_comb begin
        settle_d = settle_q;
        if (acc || cam.write_busy) begin
            settle_d = SETTLE_LOAD;
        end else if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_d;
        end
    end

    logic samp;
    assign samp = check_en_i & ~acc & ~cam.write_busy & (settle_q == '0);

    // ------------------------------------------------------------------
    // Expected result from the shadow table
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      exp_many, exp_single;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  exp_match;

    always_comb begin
        exp_many = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_many[i] = shadow_valid_q[i] & (shadow_data_q[i] == cam.compare_data);
        end
    end

    cam_prio_enc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_enc (
        .vec_i    (exp_many),
        .onehot_o (exp_single),
        .addr_o   (exp_addr),
        .any_o    (exp_match)
    );

    // ------------------------------------------------------------------
    // Latency pipeline; stage LAST lines up with the CAM outputs
    // ------------------------------------------------------------------
    logic [MATCH_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DEPTH-1:0]         pipe_many_q   [MATCH_LATENCY];
    logic [DEPTH-1:0]         pipe_many_d   [MATCH_LATENCY];
    logic [DEPTH-1:0]         pipe_single_q [MATCH_LATENCY];
    logic [DEPTH-1:0]         pipe_single_d [MATCH_LATENCY];
    logic [ADDR_WIDTH-1:0]    pipe_addr_q   [MATCH_LATENCY];
    logic [ADDR_WIDTH-1:0]    pipe_addr_d   [MATCH_LATENCY];
    logic [MATCH_LATENCY-1:0] pipe_match_q, pipe_match_d;
    logic [DATA_WIDTH-1:0]    pipe_data_q   [MATCH_LATENCY];
    logic [DATA_WIDTH-1:0]    pipe_data_d   [MATCH_LATENCY];

    always_comb begin
        pipe_vld_d    = '0;
        pipe_many_d   = pipe_many_q;
        pipe_single_d = pipe_single_q;
        pipe_addr_d   = pipe_addr_q;
        pipe_match_d  = pipe_match_q;
        pipe_data_d   = pipe_data_q;

        // samp already excludes acc, so stage 0 is flushed implicitly
        pipe_vld_d[0]    = samp;
        pipe_many_d[0]   = exp_many;
        pipe_single_d[0] = exp_single;
        pipe_addr_d[0]   = exp_addr;
        pipe_match_d[0]  = exp_match;
        pipe_data_d[0]   = cam.compare_data;

        for (int s = 1; s < MATCH_LATENCY; s++) begin
            pipe_vld_d[s]    = pipe_vld_q[s-1] & ~acc;
            pipe_many_d[s]   = pipe_many_q[s-1];
            pipe_single_d[s] = pipe_single_q[s-1];
            pipe_addr_d[s]   = pipe_addr_q[s-1];
            pipe_match_d[s]  = pipe_match_q[s-1];
            pipe_data_d[s]   = pipe_data_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Payload travels with its valid bit and needs no reset
    always_ff @(posedge clk) begin
        pipe_many_q   <= pipe_many_d;
        pipe_single_q <= pipe_single_d;
        pipe_addr_q   <= pipe_addr_d;
        pipe_match_q  <= pipe_match_d;
        pipe_data_q   <= pipe_data_d;
    end

    // ------------------------------------------------------------------
    // Compare against the CAM
    // ------------------------------------------------------------------
    // A write accepted while the last stage is valid also invalidates it:
    // that sample is still in flight and would race the table update.
    logic chk_vld;
    assign chk_vld = pipe_vld_q[LAST] & ~acc;

    logic [ERR_KIND_W-1:0] kind;

    always_comb begin
        kind             = '0;
        kind[ERR_MATCH]  = cam.match != pipe_match_q[LAST];
        // match_addr carries no meaning when nothing should match
        kind[ERR_ADDR]   = pipe_match_q[LAST] & (cam.match_addr != pipe_addr_q[LAST]);
        kind[ERR_MANY]   = cam.match_many != pipe_many_q[LAST];
        kind[ERR_SINGLE] = cam.match_single != pipe_single_q[LAST];
    end

    // ------------------------------------------------------------------
    // Statistics and first-error capture
    // ------------------------------------------------------------------
    cnt_t                  cmp_count_q, cmp_count_d;
    cnt_t                  hit_count_q, hit_count_d;
    cnt_t                  err_count_q, err_count_d;
    logic                  err_flag_q, err_flag_d;
    logic [ERR_KIND_W-1:0] err_kind_q, err_kind_d;
    logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
    logic [ADDR_WIDTH-1:0] err_exp_addr_q, err_exp_addr_d;
    logic [ADDR_WIDTH-1:0] err_got_addr_q, err_got_addr_d;

    always_comb begin
        cmp_count_d    = cmp_count_q;
        hit_count_d    = hit_count_q;
        err_count_d    = err_count_q;
        err_flag_d     = err_flag_q;
        err_kind_d     = err_kind_q;
        err_data_d     = err_data_q;
        err_exp_addr_d = err_exp_addr_q;
        err_got_addr_d = err_got_addr_q;

        if (clear_stats_i) begin
            // Wins over a check landing in the same cycle
            cmp_count_d    = '0;
            hit_count_d    = '0;
            err_count_d    = '0;
            err_flag_d     = 1'b0;
            err_kind_d     = '0;
            err_data_d     = '0;
            err_exp_addr_d = '0;
            err_got_addr_d = '0;
        end else if (chk_vld) begin
            cmp_count_d = sat_inc(cmp_count_q, 1'b1);
            hit_count_d = sat_inc(hit_count_q, pipe_match_q[LAST]);
            err_count_d = sat_inc(err_count_q, |kind);
            if ((|kind) && !err_flag_q) begin
                err_flag_d     = 1'b1;
                err_kind_d     = kind;
                err_data_d     = pipe_data_q[LAST];
                err_exp_addr_d = pipe_addr_q[LAST];
                err_got_addr_d = cam.match_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_count_q    <= '0;
            hit_count_q    <= '0;
            err_count_q    <= '0;
            err_flag_q     <= 1'b0;
            err_kind_q     <= '0;
            err_data_q     <= '0;
            err_exp_addr_q <= '0;
            err_got_addr_q <= '0;
        end else begin
            cmp_count_q    <= cmp_count_d;
            hit_count_q    <= hit_count_d;
            err_count_q    <= err_count_d;
            err_flag_q     <= err_flag_d;
            err_kind_q     <= err_kind_d;
            err_data_q     <= err_data_d;
            err_exp_addr_q <= err_exp_addr_d;
            err_got_addr_q <= err_got_addr_d;
        end
    end

    assign cmp_count_o    = cmp_count_q;
    assign hit_count_o    = hit_count_q;
    assign err_count_o    = err_count_q;
    assign err_flag_o     = err_flag_q;
    assign err_kind_o     = err_kind_q;
    assign err_data_o     = err_data_q;
    assign err_exp_addr_o = err_exp_addr_q;
    assign err_got_addr_o = err_got_addr_q;

endmodule : cam_match_checker
`default_nettype wire

// File: tb/tb_cam_match_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cam_match_checker                                            |
// | Purpose  : Directed bench for cam_match_checker. Two checkers share one    |
// |            CAM bus: index 0 at MATCH_LATENCY=1, index 1 at 3. CAM answers  |
// |            are held for three cycles so both see the same reply.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cam_match_checker;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic check_en = 1'b0;
    logic clear_stats = 1'b0;

    always #5 clk = ~clk;

    cam_match_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cam_if ();

    logic [31:0]   o_cmp   [2];
    logic [31:0]   o_hit   [2];
    logic [31:0]   o_err   [2];
    logic          o_flag  [2];
    logic [3:0]    o_kind  [2];
    logic [DW-1:0] o_data  [2];
    logic [AW-1:0] o_xaddr [2];
    logic [AW-1:0] o_gaddr [2];

    cam_match_checker #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(1), .SETTLE_CYCLES(SETTLE)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .cam(cam_if),
        .check_en_i(check_en), .clear_stats_i(clear_stats),
        .cmp_count_o(o_cmp[0]), .hit_count_o(o_hit[0]), .err_count_o(o_err[0]),
        .err_flag_o(o_flag[0]), .err_kind_o(o_kind[0]), .err_data_o(o_data[0]),
        .err_exp_addr_o(o_xaddr[0]), .err_got_addr_o(o_gaddr[0])
    );

    cam_match_checker #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(3), .SETTLE_CYCLES(SETTLE)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .cam(cam_if),
        .check_en_i(check_en), .clear_stats_i(clear_stats),
        .cmp_count_o(o_cmp[1]), .hit_count_o(o_hit[1]), .err_count_o(o_err[1]),
        .err_flag_o(o_flag[1]), .err_kind_o(o_kind[1]), .err_data_o(o_data[1]),
        .err_exp_addr_o(o_xaddr[1]), .err_got_addr_o(o_gaddr[1])
    );

    typedef struct {
        logic          clr;       // pulse clear_stats before this vector
        logic          wr;        // one write before this vector
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          wdel;
        logic [DW-1:0] key;
        logic [31:0]   c_many;    // CAM reply
        logic [31:0]   c_single;
        logic [AW-1:0] c_addr;
        logic          c_match;
        logic [31:0]   e_cmp;     // expected state afterwards
        logic [31:0]   e_hit;
        logic [31:0]   e_err;
        logic          e_flag;
        logic [3:0]    e_kind;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_xa;
        logic [AW-1:0] e_ga;
    } vec_t;

    vec_t vecs [9];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic string dname(input int which);
        return (which == 0) ? "lat1" : "lat3";
    endfunction

    task automatic check_cnt(input string tag, input int which,
                             input logic [31:0] e_cmp, e_hit, e_err);
        chk({tag, "/", dname(which), " cmp_count"}, 64'(o_cmp[which]), 64'(e_cmp));
        chk({tag, "/", dname(which), " hit_count"}, 64'(o_hit[which]), 64'(e_hit));
        chk({tag, "/", dname(which), " err_count"}, 64'(o_err[which]), 64'(e_err));
    endtask

    task automatic check_cap(input string tag, input int which, input logic e_flag,
                             input logic [3:0] e_kind, input logic [DW-1:0] e_data,
                             input logic [AW-1:0] e_xa, e_ga);
        chk({tag, "/", dname(which), " err_flag"},     64'(o_flag[which]),  64'(e_flag));
        chk({tag, "/", dname(which), " err_kind"},     64'(o_kind[which]),  64'(e_kind));
        chk({tag, "/", dname(which), " err_data"},     64'(o_data[which]),  64'(e_data));
        chk({tag, "/", dname(which), " err_exp_addr"}, 64'(o_xaddr[which]), 64'(e_xa));
        chk({tag, "/", dname(which), " err_got_addr"}, 64'(o_gaddr[which]), 64'(e_ga));
    endtask

    task automatic cam_drive(input logic [31:0] many, input logic [31:0] single,
                             input logic [AW-1:0] addr, input logic m);
        cam_if.match_many   = many;
        cam_if.match_single = single;
        cam_if.match_addr   = addr;
        cam_if.match        = m;
    endtask

    // One write, then enough idle cycles for the settle counter to expire
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic del);
        cam_if.write_addr   = addr;
        cam_if.write_data   = data;
        cam_if.write_delete = del;
        cam_if.write_enable = 1'b1;
        @(negedge clk);
        cam_if.write_enable = 1'b0;
        repeat (SETTLE + 1) @(negedge clk);
    endtask

    // One-cycle sample; the CAM reply (and optional clear) covers the check
    // cycle of both latencies; returns once all counters have updated.
    task automatic do_sample(input logic [DW-1:0] key, input logic [31:0] many,
                             input logic [31:0] single, input logic [AW-1:0] addr,
                             input logic m, input logic clr);
        cam_if.compare_data = key;
        check_en = 1'b1;
        @(negedge clk);
        check_en = 1'b0;
        cam_drive(many, single, addr, m);
        clear_stats = clr;
        repeat (3) @(negedge clk);
        cam_drive('0, '0, '0, 1'b0);
        clear_stats = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        cam_if.write_addr   = '0;
        cam_if.write_data   = '0;
        cam_if.write_delete = 1'b0;
        cam_if.write_enable = 1'b0;
        cam_if.write_busy   = 1'b0;
        cam_if.compare_data = '0;
        cam_drive('0, '0, '0, 1'b0);

        //        clr   wr    waddr  wdata         wdel  key           c_many        c_single      c_addr c_m   cmp    hit    err    flag  kind     data          xa     ga
        vecs[0] = '{1'b0, 1'b0, 5'd0,  64'h0,        1'b0, 64'h400,      32'h0,        32'h0,        5'd0,  1'b0, 32'd1, 32'd0, 32'd0, 1'b0, 4'b0000, 64'h0,        5'd0,  5'd0};
        vecs[1] = '{1'b0, 1'b1, 5'd3,  64'h1,        1'b0, 64'h1,        32'h8,        32'h8,        5'd3,  1'b1, 32'd2, 32'd1, 32'd0, 1'b0, 4'b0000, 64'h0,        5'd0,  5'd0};
        vecs[2] = '{1'b0, 1'b1, 5'd5,  64'h7,        1'b0, 64'h7,        32'h20,       32'h20,       5'd5,  1'b1, 32'd3, 32'd2, 32'd0, 1'b0, 4'b0000, 64'h0,        5'd0,  5'd0};
        vecs[3] = '{1'b0, 1'b1, 5'd2,  64'h7,        1'b0, 64'h7,        32'h24,       32'h4,        5'd5,  1'b1, 32'd4, 32'd3, 32'd1, 1'b1, 4'b0010, 64'h7,        5'd2,  5'd5};
        vecs[4] = '{1'b1, 1'b1, 5'd3,  64'h0,        1'b1, 64'h1,        32'h8,        32'h8,        5'd3,  1'b1, 32'd1, 32'd0, 32'd1, 1'b1, 4'b1101, 64'h1,        5'd0,  5'd3};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  64'h0,        1'b0, 64'h7,        32'h24,       32'h4,        5'd2,  1'b1, 32'd2, 32'd1, 32'd1, 1'b1, 4'b1101, 64'h1,        5'd0,  5'd3};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  64'h0,        1'b0, 64'h1,        32'h0,        32'h0,        5'd9,  1'b0, 32'd3, 32'd1, 32'd1, 1'b1, 4'b1101, 64'h1,        5'd0,  5'd3};
        vecs[7] = '{1'b0, 1'b1, 5'd31, 64'hDEAD,     1'b0, 64'hDEAD,     32'h8000_0000, 32'h8000_0000, 5'd31, 1'b1, 32'd4, 32'd2, 32'd1, 1'b1, 4'b1101, 64'h1,        5'd0,  5'd3};
        vecs[8] = '{1'b0, 1'b1, 5'd0,  64'hDEAD,     1'b0, 64'hDEAD,     32'h8000_0001, 32'h8000_0000, 5'd31, 1'b1, 32'd5, 32'd3, 32'd2, 1'b1, 4'b1101, 64'h1,        5'd0,  5'd3};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check_cnt("reset", w, 32'd0, 32'd0, 32'd0);
            check_cap("reset", w, 1'b0, 4'b0000, 64'h0, 5'd0, 5'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].clr) begin
                clear_stats = 1'b1;
                @(negedge clk);
                clear_stats = 1'b0;
            end
            if (vecs[v].wr) begin
                do_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wdel);
            end
            do_sample(vecs[v].key, vecs[v].c_many, vecs[v].c_single,
                      vecs[v].c_addr, vecs[v].c_match, 1'b0);
            for (int w = 0; w < 2; w++) begin
                check_cnt($sformatf("vec%0d", v), w, vecs[v].e_cmp, vecs[v].e_hit, vecs[v].e_err);
                check_cap($sformatf("vec%0d", v), w, vecs[v].e_flag, vecs[v].e_kind,
                          vecs[v].e_data, vecs[v].e_xa, vecs[v].e_ga);
            end
        end

        // ---------------- write during an in-flight sample ----------------
        // Sample in cycle c, write accepted in c+2: latency 1 already checked
        // it, latency 3 must drop it.
        cam_if.compare_data = 64'h400;
        check_en = 1'b1;
        @(negedge clk);
        check_en = 1'b0;
        @(negedge clk);
        cam_if.write_addr   = 5'd10;
        cam_if.write_data   = 64'h55;
        cam_if.write_delete = 1'b0;
        cam_if.write_enable = 1'b1;
        @(negedge clk);
        cam_if.write_enable = 1'b0;
        // Settle holds sampling off for 4 cycles after the write
        check_en = 1'b1;
        repeat (SETTLE) @(negedge clk);
        check_en = 1'b0;
        repeat (5) @(negedge clk);
        check_cnt("flush", 0, 32'd6, 32'd3, 32'd2);
        check_cnt("flush", 1, 32'd5, 32'd3, 32'd2);

        do_sample(64'h400, '0, '0, '0, 1'b0, 1'b0);
        check_cnt("post_settle", 0, 32'd7, 32'd3, 32'd2);
        check_cnt("post_settle", 1, 32'd6, 32'd3, 32'd2);

        // Busy blocks sampling and writes, and restarts the settle window
        cam_if.write_addr   = 5'd4;
        cam_if.write_data   = 64'h400;
        cam_if.write_enable = 1'b1;
        cam_if.write_busy   = 1'b1;
        cam_if.compare_data = 64'h400;
        check_en = 1'b1;
        @(negedge clk);
        cam_if.write_enable = 1'b0;
        cam_if.write_busy   = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check_en = 1'b0;
        repeat (5) @(negedge clk);
        check_cnt("busy_hold", 0, 32'd7, 32'd3, 32'd2);
        check_cnt("busy_hold", 1, 32'd6, 32'd3, 32'd2);

        // Entry 4 must not have been written while busy: still a clean miss
        do_sample(64'h400, '0, '0, '0, 1'b0, 1'b0);
        check_cnt("busy_nowrite", 0, 32'd8, 32'd3, 32'd2);
        check_cnt("busy_nowrite", 1, 32'd7, 32'd3, 32'd2);

        // ---------------- error counter saturation ----------------
        @(negedge clk);
        force dut_a.err_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut_a.err_count_q;
        do_sample(64'h400, '0, '0, '0, 1'b1, 1'b0);
        chk("sat1/lat1 err_count", 64'(o_err[0]), 64'hFFFF_FFFF);
        do_sample(64'h400, '0, '0, '0, 1'b1, 1'b0);
        do_sample(64'h400, '0, '0, '0, 1'b1, 1'b0);
        check_cnt("sat3", 0, 32'd11, 32'd3, 32'hFFFF_FFFF);
        check_cnt("sat3", 1, 32'd10, 32'd3, 32'd5);

        // ---------------- clear_stats coinciding with an error ----------------
        do_sample(64'h400, '0, '0, '0, 1'b1, 1'b1);
        for (int w = 0; w < 2; w++) begin
            check_cnt("clr_err", w, 32'd0, 32'd0, 32'd0);
            check_cap("clr_err", w, 1'b0, 4'b0000, 64'h0, 5'd0, 5'd0);
        end
        // Shadow survives clear: entries 2 and 5 still hold 7
        do_sample(64'h7, 32'h24, 32'h4, 5'd2, 1'b1, 1'b0);
        for (int w = 0; w < 2; w++) begin
            check_cnt("after_clr", w, 32'd1, 32'd1, 32'd0);
        end

        // ---------------- reset during an in-flight sample ----------------
        cam_if.compare_data = 64'h7;
        check_en = 1'b1;
        @(negedge clk);
        check_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_cnt("rst_flight", 1, 32'd0, 32'd0, 32'd0);
        // Reset invalidated the shadow: key 7 is now an expected miss
        do_sample(64'h7, '0, '0, '0, 1'b0, 1'b0);
        for (int w = 0; w < 2; w++) begin
            check_cnt("rst_shadow", w, 32'd1, 32'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cam_match_checker
`default_nettype wire
